// File: rtl/fc_pkg.sv
// Shared types and sizing for the fully-connected activation loader.
package fc_pkg;
    localparam int WIDTH = 8;
    localparam int IN    = 128;
    localparam int CNT_W = $clog2(IN);

    typedef logic [WIDTH-1:0] act_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;
endpackage

// File: rtl/fc_act_bank.sv
// One frame of activation storage: indexed single-beat write, full parallel read-out.
module fc_act_bank
    import fc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] idx_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o [IN]
);

    logic [WIDTH-1:0] mem_q [IN];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < IN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/fc_act_loader.sv
// Ping-pong frame assembler: serial activation beats in, one stable parallel frame out.
// bank state | meaning
// EMPTY      | free, next beat for this bank starts a new frame
// FILLING    | at least one beat written, frame incomplete
// FULL       | complete frame, presented on x_o when this is the read bank
module fc_act_loader
    import fc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] x_o [IN],
    output logic             x_valid_o,
    input  logic             x_ready_i,
    output logic             err_len_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN - 1);

    bank_state_t      state_q [2];
    bank_state_t      state_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_len_q, err_len_d;

    logic             accept;
    logic             release_frame;
    logic [WIDTH-1:0] bank0_data [IN];
    logic [WIDTH-1:0] bank1_data [IN];

    assign s_ready_o     = (state_q[wr_bank_q] != BANK_FULL);
    assign x_valid_o     = (state_q[rd_bank_q] == BANK_FULL);
    assign err_len_o     = err_len_q;
    assign accept        = s_valid_i && s_ready_o;
    assign release_frame = x_valid_o && x_ready_i;

    fc_act_bank u_bank0 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (accept && !wr_bank_q),
        .idx_i   (count_q),
        .data_i  (s_data_i),
        .data_o  (bank0_data)
    );

    fc_act_bank u_bank1 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (accept && wr_bank_q),
        .idx_i   (count_q),
        .data_i  (s_data_i),
        .data_o  (bank1_data)
    );

    always_comb begin
        for (int i = 0; i < IN; i++) begin
            x_o[i] = rd_bank_q ? bank1_data[i] : bank0_data[i];
        end
    end

    // Release and commit can never target the same bank: release needs the
    // read bank FULL, accept needs the write bank not FULL.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        count_d   = count_q;
        err_len_d = 1'b0;

        if (release_frame) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = !rd_bank_q;
        end

        if (accept) begin
            if (count_q == LAST_IDX) begin
                state_d[wr_bank_q] = BANK_FULL;
                wr_bank_d          = !wr_bank_q;
                count_d            = '0;
                err_len_d          = !s_last_i;
            end else if (s_last_i) begin
                state_d[wr_bank_q] = BANK_EMPTY;
                count_d            = '0;
                err_len_d          = 1'b1;
            end else begin
                state_d[wr_bank_q] = BANK_FILLING;
                count_d            = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            count_q    <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            count_q    <= count_d;
            err_len_q  <= err_len_d;
        end
    end

endmodule
